// File: rtl/cdl_reg_ctrl_if.sv
// cdl_reg_ctrl_if
//
// Host request/response bundle for the CDL register access controller.
//
// Signals:
//   req_valid  host request present
//   req_ready  controller can accept a request
//   req_write  1 = write, 0 = read
//   req_addr   register index (AW bits)
//   req_wdata  write data (DW bits)
//   rsp_valid  response present
//   rsp_ready  host accepts response
//   rsp_rdata  read data (0 for writes and errors)
//   rsp_err    request rejected
//
// Modports:
//   master  host side, drives requests and rsp_ready
//   slave   controller side, drives req_ready and the response
interface cdl_reg_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/cdl_reg_ctrl.sv
// cdl_reg_ctrl
//
// Host-side access controller for the CDL register bank. Accepts one read or
// write at a time over a valid/ready handshake, executes it in a single EXEC
// cycle and holds the response until the host takes it. Each register has a
// single driver: host writes and per-register hw_set pulses are merged here,
// with hw_set owning bit 0 when both hit the same register in one cycle.
//
// Ports:
//   clk      clock, all state updates on posedge
//   reset_l  synchronous active-low reset
//   bus      request/response bundle (slave side)
//   lock     write protect, sampled in EXEC; reads are unaffected
//   hw_set   per-register pulse forcing bit 0 of that register to 1
//   reg_q    flattened register contents, register i at [i*DW +: DW]
module cdl_reg_ctrl #(
    parameter int unsigned NREGS = 5,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 3
) (
    input  logic                clk,
    input  logic                reset_l,
    cdl_reg_ctrl_if.slave       bus,
    input  logic                lock,
    input  logic [NREGS-1:0]    hw_set,
    output logic [NREGS*DW-1:0] reg_q
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e        state_q, state_d;

    // Captured request
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    // Registered response, stable for the whole RESP phase
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];

    logic          in_range;
    logic          wr_ok;
    logic [DW-1:0] rd_mux;

    // Address decode and read mux over the captured address. The mux is a
    // loop so out-of-range addresses read as 0 instead of indexing past the
    // bank when NREGS is not a power of two.
    always_comb begin
        in_range = (32'(addr_q) < NREGS);
        rd_mux   = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (addr_q == AW'(i)) begin
                rd_mux = regs_q[i];
            end
        end
    end

    // Next-state and request/response bookkeeping
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_ok   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (!in_range || (wr_q && lock)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (wr_q) begin
                    wr_ok   = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end else begin
                    // Reads see the value at the start of EXEC, before any
                    // hw_set landing on this same edge.
                    err_d   = 1'b0;
                    rdata_d = rd_mux;
                end
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Register bank merge: host write first, then hw_set overrides bit 0 only
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && (addr_q == AW'(i))) begin
                regs_d[i] = wdata_q;
            end
            if (hw_set[i]) begin
                regs_d[i][0] = 1'b1;
            end
        end
    end

    // Reset also discards an in-flight request: no write, no response.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Outputs decoded from state or taken straight from flops. req_ready is
    // additionally gated by reset_l so it reads 0 for the whole reset window.
    assign bus.req_ready = reset_l && (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            reg_q[i*DW +: DW] = regs_q[i];
        end
    end

endmodule

// File: tb/tb_cdl_reg_ctrl.sv
// tb_cdl_reg_ctrl
//
// Self-checking bench for cdl_reg_ctrl: a directed table of transactions,
// hand-written hw_set and mid-transaction reset sequences, then randomized
// transactions with random hw_set traffic checked against a register-array
// model of the bank.
module tb_cdl_reg_ctrl;

    localparam int unsigned NREGS = 5;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;

    logic                clk;
    logic                reset_l;
    logic                lock;
    logic [NREGS-1:0]    hs;
    logic [NREGS*DW-1:0] reg_q;

    cdl_reg_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    cdl_reg_ctrl #(
        .NREGS(NREGS),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk    (clk),
        .reset_l(reset_l),
        .bus    (bus),
        .lock   (lock),
        .hw_set (hs),
        .reg_q  (reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference bank contents
    logic [DW-1:0] mdl [NREGS];
    // Pending write to commit on the next edge (set during the EXEC cycle)
    bit            exec_wr = 1'b0;
    int            exec_a  = 0;
    logic [DW-1:0] exec_d  = '0;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            lk;
        int            hold;
        logic [NREGS-1:0] hs_exec;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            chk_reg;
        logic [DW-1:0] chk_val;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREGS*DW-1:0] flat_mdl();
        logic [NREGS*DW-1:0] f;
        f = '0;
        for (int i = 0; i < NREGS; i++) f[i*DW +: DW] = mdl[i];
        return f;
    endfunction

    // One clock: update the model from the inputs seen at the edge, then
    // compare the exported bank.
    task automatic tick();
        @(posedge clk);
        if (!reset_l) begin
            for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        end else begin
            if (exec_wr) mdl[exec_a] = exec_d;
            for (int i = 0; i < NREGS; i++) begin
                if (hs[i]) mdl[i][0] = 1'b1;
            end
        end
        exec_wr = 1'b0;
        #1;
        chk("reg_q", 64'(reg_q), 64'(flat_mdl()));
    endtask

    // Full transaction from IDLE back to IDLE with timing checks. Expected
    // response is derived from the model at the start of EXEC.
    task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit lk, input int hold, input logic [NREGS-1:0] hs_exec,
                       input bit rnd_hs, output logic [DW-1:0] r, output bit e);
        logic [DW-1:0] er;
        bit            ee;
        // IDLE: present request
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = 1'b0;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        tick();
        // EXEC
        bus.req_valid = 1'b0;
        lock = lk;
        hs   = hs_exec;
        chk("req_ready_exec", 64'(bus.req_ready), 64'd0);
        chk("rsp_valid_exec", 64'(bus.rsp_valid), 64'd0);
        ee = (int'(a) >= NREGS) || (wr && lk);
        er = (!ee && !wr) ? mdl[a] : '0;
        if (!ee && wr) begin
            exec_wr = 1'b1;
            exec_a  = int'(a);
            exec_d  = d;
        end
        tick();
        // RESP, host stalls for 'hold' cycles with a competing request pending
        hs   = '0;
        lock = 1'($urandom);
        for (int k = 0; k < hold; k++) begin
            chk("rsp_valid_hold", 64'(bus.rsp_valid), 64'd1);
            chk("rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(er));
            chk("rsp_err_hold", 64'(bus.rsp_err), 64'(ee));
            chk("req_ready_hold", 64'(bus.req_ready), 64'd0);
            bus.req_valid = 1'b1;
            bus.req_write = 1'($urandom);
            bus.req_addr  = AW'($urandom);
            bus.req_wdata = DW'($urandom);
            hs = rnd_hs ? NREGS'($urandom) : '0;
            tick();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        hs = rnd_hs ? NREGS'($urandom) : '0;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(er));
        chk("rsp_err", 64'(bus.rsp_err), 64'(ee));
        chk("req_ready_resp", 64'(bus.req_ready), 64'd0);
        r = bus.rsp_rdata;
        e = bus.rsp_err;
        tick();
        // Back in IDLE
        bus.rsp_ready = 1'b0;
        hs = '0;
        chk("rsp_valid_after", 64'(bus.rsp_valid), 64'd0);
        chk("req_ready_after", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] r;
        bit            e;

        vecs[0] = '{1'b1, 3'd2, 8'hA5, 1'b0, 0, 5'b00000, 8'h00, 1'b0, 2, 8'hA5};
        vecs[1] = '{1'b0, 3'd2, 8'h00, 1'b0, 0, 5'b00000, 8'hA5, 1'b0, 2, 8'hA5};
        vecs[2] = '{1'b0, 3'd6, 8'h00, 1'b0, 0, 5'b00000, 8'h00, 1'b1, 2, 8'hA5};
        vecs[3] = '{1'b1, 3'd1, 8'h3C, 1'b1, 0, 5'b00000, 8'h00, 1'b1, 1, 8'h00};
        vecs[4] = '{1'b0, 3'd1, 8'h00, 1'b1, 0, 5'b00000, 8'h00, 1'b0, 1, 8'h00};
        vecs[5] = '{1'b1, 3'd0, 8'h40, 1'b0, 0, 5'b00001, 8'h00, 1'b0, 0, 8'h41};
        vecs[6] = '{1'b1, 3'd4, 8'h77, 1'b0, 0, 5'b00000, 8'h00, 1'b0, 4, 8'h77};
        vecs[7] = '{1'b0, 3'd4, 8'h00, 1'b0, 5, 5'b00000, 8'h77, 1'b0, 4, 8'h77};

        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        reset_l       = 1'b0;
        lock          = 1'b0;
        hs            = '0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) begin
            tick();
            chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
            chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        end
        reset_l = 1'b1;
        #1;
        chk("rel_req_ready", 64'(bus.req_ready), 64'd1);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lk, vecs[i].hold,
                vecs[i].hs_exec, 1'b0, r, e);
            chk($sformatf("vec%0d_rdata", i), 64'(r), 64'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_reg", i), 64'(reg_q[vecs[i].chk_reg*DW +: DW]),
                64'(vecs[i].chk_val));
        end

        // hw_set[3] while idle lands one cycle later
        chk("hs3_before", 64'(reg_q[3*DW]), 64'd0);
        hs = 5'b01000;
        tick();
        hs = '0;
        chk("hs3_after", 64'(reg_q[3*DW]), 64'd1);
        chk("hs3_idle", 64'(bus.req_ready), 64'd1);

        // Randomized transactions with background hw_set traffic
        for (int n = 0; n < 60; n++) begin
            txn(1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), NREGS'($urandom), 1'b1, r, e);
            repeat ($urandom_range(0, 2)) begin
                hs = NREGS'($urandom);
                tick();
                chk("gap_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            end
            hs = '0;
        end

        // Reset during EXEC of a write 0xFF to register 4
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 3'd4;
        bus.req_wdata = 8'hFF;
        lock          = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        reset_l       = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("mid_rst_req_ready_hold", 64'(bus.req_ready), 64'd0);
            hs = NREGS'($urandom);
            tick();
        end
        hs      = '0;
        reset_l = 1'b1;
        #1;
        chk("mid_rst_release_ready", 64'(bus.req_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
            chk("mid_rst_reg4", 64'(reg_q[4*DW +: DW]), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
